// File: rtl/plot_arbiter.sv
// Round-robin arbiter sharing the VGA write port between sprite requesters.
// Each grant scans one SIZE x SIZE square pixel by pixel, clipping off-screen pixels.
module plot_arbiter #(
    parameter int N_REQ    = 4,
    parameter int SIZE     = 4,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int C_W      = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*X_W-1:0] req_x,
    input  logic [N_REQ*Y_W-1:0] req_y,
    input  logic [N_REQ*C_W-1:0] req_colour,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [C_W-1:0]     vga_colour,
    output logic               vga_plot
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LOG_S = $clog2(SIZE);
    localparam int CNT_W = 2 * LOG_S;
    localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);
    localparam logic [CNT_W-1:0] CNT_LAST = '1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, PLOT, DONE} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [X_W-1:0]   base_x_q, base_x_d;
    logic [Y_W-1:0]   base_y_q, base_y_d;
    logic [C_W-1:0]   colour_q, colour_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [X_W-1:0]   last_x_q, last_x_d;
    logic [Y_W-1:0]   last_y_q, last_y_d;
    logic [C_W-1:0]   last_c_q, last_c_d;

    logic             found;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] cand;
    logic [N_REQ-1:0] owner_oh;
    logic [X_W:0]     pix_x;
    logic [Y_W:0]     pix_y;

    // First requesting index at or after rr_ptr, wrapping upward.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = PTR_W'((int'(rr_ptr_q) + i) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // One extra bit so coordinates past the edge are clipped, not wrapped.
    assign pix_x = {1'b0, base_x_q} + (X_W+1)'(cnt_q[LOG_S-1:0]);
    assign pix_y = {1'b0, base_y_q} + (Y_W+1)'(cnt_q[CNT_W-1:LOG_S]);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        colour_d = colour_q;
        cnt_d    = cnt_q;
        last_x_d = last_x_q;
        last_y_d = last_y_q;
        last_c_d = last_c_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d  = win;
                    base_x_d = req_x[win*X_W +: X_W];
                    base_y_d = req_y[win*Y_W +: Y_W];
                    colour_d = req_colour[win*C_W +: C_W];
                    cnt_d    = '0;
                    state_d  = PLOT;
                end
            end
            PLOT: begin
                cnt_d    = cnt_q + 1'b1;
                last_x_d = pix_x[X_W-1:0];
                last_y_d = pix_y[Y_W-1:0];
                last_c_d = colour_q;
                if (cnt_q == CNT_LAST) state_d = DONE;
            end
            DONE: begin
                rr_ptr_d = (owner_q == PTR_LAST) ? '0 : owner_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            base_x_q <= '0;
            base_y_q <= '0;
            colour_q <= '0;
            cnt_q    <= '0;
            last_x_q <= '0;
            last_y_q <= '0;
            last_c_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            colour_q <= colour_d;
            cnt_q    <= cnt_d;
            last_x_q <= last_x_d;
            last_y_q <= last_y_d;
            last_c_q <= last_c_d;
        end
    end

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    assign busy       = (state_q != IDLE);
    assign grant      = (state_q == PLOT && cnt_q == '0) ? owner_oh : '0;
    assign done       = (state_q == DONE) ? owner_oh : '0;
    assign vga_x      = (state_q == PLOT) ? pix_x[X_W-1:0] : last_x_q;
    assign vga_y      = (state_q == PLOT) ? pix_y[Y_W-1:0] : last_y_q;
    assign vga_colour = (state_q == PLOT) ? colour_q : last_c_q;
    assign vga_plot   = (state_q == PLOT) && (pix_x < X_LIM) && (pix_y < Y_LIM);

endmodule

// File: tb/tb_plot_arbiter.sv
// Bench for plot_arbiter: directed scenarios plus random requests
// checked against a round-robin / square-scan reference model.
module tb_plot_arbiter;

    localparam int N = 4, S = 4, XW = 8, YW = 7, CW = 3;
    localparam int SW = 160, SH = 120, NPIX = S * S;
    localparam int PW = XW + YW + CW + 1;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*XW-1:0] req_x;
    logic [N*YW-1:0] req_y;
    logic [N*CW-1:0] req_colour;
    logic [N-1:0]    grant, done;
    logic            busy, vga_plot;
    logic [XW-1:0]   vga_x;
    logic [YW-1:0]   vga_y;
    logic [CW-1:0]   vga_colour;

    plot_arbiter dut (
        .clock(clock), .reset(reset), .req(req),
        .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
        .grant(grant), .done(done), .busy(busy),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    int rr = 0;

    // observations of one operation
    int            o_wait;
    logic [N-1:0]  o_grant, o_done, o_grant_at_done;
    logic          o_busy_done, o_busy_after;
    logic [PW-1:0] o_pix [NPIX];
    logic [PW-1:0] o_hold;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    function automatic logic [PW-1:0] pix(input int bx, input int by,
                                          input int bc, input int k);
        int ex, ey;
        logic [XW-1:0] tx;
        logic [YW-1:0] ty;
        logic [CW-1:0] tc;
        ex = bx + k % S;
        ey = by + k / S;
        tx = ex[XW-1:0];
        ty = ey[YW-1:0];
        tc = bc[CW-1:0];
        return {tx, ty, tc, (ex < SW && ey < SH)};
    endfunction

    function automatic logic [PW-1:0] held(input int bx, input int by, input int bc);
        logic [PW-1:0] v;
        v = pix(bx, by, bc, NPIX - 1);
        v[0] = 1'b0;
        return v;
    endfunction

    // Records one operation; only observes, never judges.
    task automatic capture(input bit drop, input int poke_k,
                           input int poke_i, input logic [XW-1:0] poke_x);
        o_wait = 0;
        do begin
            @(negedge clock);
            o_wait++;
        end while (grant == '0 && o_wait < 100);
        o_grant = grant;
        if (drop) req = '0;
        for (int k = 0; k < NPIX; k++) begin
            o_pix[k] = {vga_x, vga_y, vga_colour, vga_plot};
            if (k == poke_k) req_x[poke_i*XW +: XW] = poke_x;
            if (k < NPIX - 1) @(negedge clock);
        end
        @(negedge clock);
        o_done = done;
        o_grant_at_done = grant;
        o_busy_done = busy;
        o_hold = {vga_x, vga_y, vga_colour, vga_plot};
        @(negedge clock);
        o_busy_after = busy;
    endtask

    task automatic set_req(input int i, input int x, input int y, input int c);
        req_x[i*XW +: XW] = XW'(x);
        req_y[i*YW +: YW] = YW'(y);
        req_colour[i*CW +: CW] = CW'(c);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req = '0;
        req_x = '0;
        req_y = '0;
        req_colour = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({grant, done, busy, vga_plot, vga_x, vga_y, vga_colour} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got g=%b d=%b b=%b p=%b x=%0d y=%0d c=%0d want all 0",
                     grant, done, busy, vga_plot, vga_x, vga_y, vga_colour);
        end
        reset = 1'b1;
        rr = 0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || grant !== '0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b grant=%b want 0 0", busy, grant);
        end
    endtask

    task automatic test_pair();
        int w;
        set_req(1, 30, 40, 2);
        set_req(2, 60, 70, 5);
        req = 4'b0110;
        for (int n = 0; n < 2; n++) begin
            w = pick(req, rr);
            capture(1'b0, -1, 0, '0);
            checks++;
            if (o_grant !== onehot(w) || o_wait !== 1) begin
                errors++;
                $display("FAIL pair_grant%0d got %b wait=%0d want %b wait=1",
                         n, o_grant, o_wait, onehot(w));
            end
            checks++;
            if (o_pix[0] !== pix(n ? 60 : 30, n ? 70 : 40, n ? 5 : 2, 0)) begin
                errors++;
                $display("FAIL pair_pix0_%0d got %h want %h", n, o_pix[0],
                         pix(n ? 60 : 30, n ? 70 : 40, n ? 5 : 2, 0));
            end
            rr = (w + 1) % N;
        end
        req = '0;
        @(negedge clock);
        // with rr at 3, requester 3 must win over requester 0
        set_req(3, 5, 5, 1);
        set_req(0, 9, 9, 4);
        req = 4'b1001;
        w = pick(req, rr);
        capture(1'b1, -1, 0, '0);
        checks++;
        if (o_grant !== onehot(w)) begin
            errors++;
            $display("FAIL pair_rrptr got %b want %b", o_grant, onehot(w));
        end
        rr = (w + 1) % N;
    endtask

    task automatic test_back_to_back();
        int w;
        for (int i = 0; i < N; i++) set_req(i, 10 * i, 5 * i, i);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            w = pick(req, rr);
            capture(1'b0, -1, 0, '0);
            checks++;
            if (o_grant !== onehot(w) || o_wait !== 1) begin
                errors++;
                $display("FAIL b2b_grant%0d got %b wait=%0d want %b wait=1",
                         n, o_grant, o_wait, onehot(w));
            end
            checks++;
            if (o_done !== onehot(w) || o_grant_at_done !== '0) begin
                errors++;
                $display("FAIL b2b_done%0d got done=%b grant=%b want %b 0",
                         n, o_done, o_grant_at_done, onehot(w));
            end
            rr = (w + 1) % N;
        end
        req = '0;
        @(negedge clock);
    endtask

    task automatic test_single();
        int w;
        set_req(0, 10, 20, 7);
        req = 4'b0001;
        w = pick(req, rr);
        capture(1'b1, -1, 0, '0);
        rr = (w + 1) % N;
        checks++;
        if (o_grant !== 4'b0001 || o_wait !== 1) begin
            errors++;
            $display("FAIL single_grant got %b wait=%0d want 0001 wait=1", o_grant, o_wait);
        end
        for (int k = 0; k < NPIX; k++) begin
            checks++;
            if (o_pix[k] !== pix(10, 20, 7, k)) begin
                errors++;
                $display("FAIL single_pix%0d got %h want %h", k, o_pix[k], pix(10, 20, 7, k));
            end
        end
        checks++;
        if (o_done !== 4'b0001 || o_busy_done !== 1'b1) begin
            errors++;
            $display("FAIL single_done got %b busy=%b want 0001 1", o_done, o_busy_done);
        end
        checks++;
        if (o_hold !== held(10, 20, 7)) begin
            errors++;
            $display("FAIL single_hold got %h want %h", o_hold, held(10, 20, 7));
        end
        checks++;
        if (o_busy_after !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_low got %b want 0", o_busy_after);
        end
    endtask

    task automatic test_clip();
        int w, plots;
        set_req(1, 158, 118, 6);
        req = 4'b0010;
        w = pick(req, rr);
        capture(1'b1, -1, 0, '0);
        rr = (w + 1) % N;
        plots = 0;
        for (int k = 0; k < NPIX; k++) begin
            plots += int'(o_pix[k][0]);
            checks++;
            if (o_pix[k] !== pix(158, 118, 6, k)) begin
                errors++;
                $display("FAIL clip_pix%0d got %h want %h", k, o_pix[k], pix(158, 118, 6, k));
            end
        end
        checks++;
        if (plots !== 4) begin
            errors++;
            $display("FAIL clip_count got %0d want 4", plots);
        end
        checks++;
        if (o_done !== onehot(w)) begin
            errors++;
            $display("FAIL clip_done got %b want %b", o_done, onehot(w));
        end
    endtask

    task automatic test_capture();
        int w;
        set_req(2, 10, 50, 3);
        req = 4'b0100;
        w = pick(req, rr);
        capture(1'b1, 3, 2, 8'd50);
        rr = (w + 1) % N;
        for (int k = 0; k < NPIX; k++) begin
            checks++;
            if (o_pix[k] !== pix(10, 50, 3, k)) begin
                errors++;
                $display("FAIL capture_pix%0d got %h want %h", k, o_pix[k], pix(10, 50, 3, k));
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        set_req(2, 40, 40, 1);
        set_req(1, 80, 60, 4);
        req = 4'b0100;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (grant == '0 && n < 100);
        req = 4'b1010;
        repeat (7) @(negedge clock);
        checks++;
        if (vga_plot !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got plot=%b busy=%b want 1 1", vga_plot, busy);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({vga_plot, busy, grant, done, vga_x} !== '0) begin
            errors++;
            $display("FAIL rstmid_drop got plot=%b busy=%b g=%b d=%b x=%0d want 0",
                     vga_plot, busy, grant, done, vga_x);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (done !== '0) begin
                errors++;
                $display("FAIL rstmid_nodone got %b want 0", done);
            end
        end
        reset = 1'b1;
        rr = 0;
        capture(1'b1, -1, 0, '0);
        checks++;
        if (o_grant !== 4'b0010 || o_pix[0] !== pix(80, 60, 4, 0)) begin
            errors++;
            $display("FAIL rstmid_regrant got %b pix=%h want 0010 %h",
                     o_grant, o_pix[0], pix(80, 60, 4, 0));
        end
        checks++;
        if (o_done !== 4'b0010) begin
            errors++;
            $display("FAIL rstmid_done got %b want 0010", o_done);
        end
        rr = 2;
    endtask

    task automatic test_random();
        int w, bx, by, bc, bad;
        logic [N-1:0] r;
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < N; i++)
                set_req(i, $urandom_range(0, 255), $urandom_range(0, 127),
                        $urandom_range(0, 7));
            r = N'($urandom_range(1, 15));
            req = r;
            w = pick(r, rr);
            bx = int'(req_x[w*XW +: XW]);
            by = int'(req_y[w*YW +: YW]);
            bc = int'(req_colour[w*CW +: CW]);
            capture(1'b1, -1, 0, '0);
            rr = (w + 1) % N;
            checks++;
            if (o_grant !== onehot(w) || o_wait !== 1) begin
                errors++;
                $display("FAIL rand%0d_grant got %b wait=%0d want %b wait=1",
                         n, o_grant, o_wait, onehot(w));
            end
            bad = 0;
            for (int k = 0; k < NPIX; k++) begin
                checks++;
                if (o_pix[k] !== pix(bx, by, bc, k)) begin
                    errors++;
                    if (bad++ < 2)
                        $display("FAIL rand%0d_pix%0d got %h want %h",
                                 n, k, o_pix[k], pix(bx, by, bc, k));
                end
            end
            checks++;
            if (o_done !== onehot(w) || o_hold !== held(bx, by, bc) ||
                o_busy_after !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_end got done=%b hold=%h busy=%b want %b %h 0",
                         n, o_done, o_hold, o_busy_after, onehot(w), held(bx, by, bc));
            end
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_back_to_back();
        test_single();
        test_clip();
        test_capture();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Shares the single VGA adapter write port (x, y, colour, plot) between several sprite requesters: player square, falling meatsquares, score box.
- Each requester asks for one SIZE x SIZE solid square at a given top-left corner and colour. Draw and erase are the same operation; erase is a request with the background colour.
- The block grants requesters round-robin, scans the square pixel by pixel, clips off-screen pixels, and pulses done to the winner when its square is finished.
- Sits between the game control FSM / object datapaths and the VGA adapter.

Parameters:
- N_REQ, 4, number of requesters.
- SIZE, 4, square side in pixels; power of two, 2..16.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- C_W, 3, colour width.
- SCREEN_W, 160, visible columns.
- SCREEN_H, 120, visible rows.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request level.
- req_x  in  N_REQ*X_W  flattened top-left x; requester i occupies bits [i*X_W +: X_W].
- req_y  in  N_REQ*Y_W  flattened top-left y; same packing.
- req_colour  in  N_REQ*C_W  flattened colour; same packing.
- grant  out  N_REQ  one-hot, one-cycle pulse when a requester's square is accepted.
- done  out  N_REQ  one-hot, one-cycle pulse when that square is fully written.
- busy  out  1  high in every state except IDLE.
- vga_x  out  X_W  pixel x to the adapter.
- vga_y  out  Y_W  pixel y to the adapter.
- vga_colour  out  C_W  pixel colour to the adapter.
- vga_plot  out  1  write enable to the adapter.

Behaviour:
- States: IDLE, PLOT, DONE. Registers: state, rr_ptr (log2 N_REQ bits), owner index, base_x, base_y, colour, pixel counter cnt (log2(SIZE*SIZE) bits).
- Reset (async, reset=0): state=IDLE, rr_ptr=0, cnt=0. grant, done, vga_plot and busy go to 0 immediately. vga_x, vga_y and vga_colour go to 0.
- An operation interrupted by reset is abandoned; no done pulse is issued for it.

IDLE:
- If any req bit is set, the winner is the first set bit at or after rr_ptr, scanning upward with wrap.
- Latch the winner's x, y and colour. Set owner, cnt=0, next state PLOT.
- grant[owner]=1 for exactly the first PLOT cycle.

PLOT:
- Pixel k=cnt. vga_x = base_x + (k mod SIZE); vga_y = base_y + (k div SIZE); vga_colour = colour.
- Sums are computed one bit wider than the coordinate.
- vga_plot=1 only if the wide x < SCREEN_W and the wide y < SCREEN_H. Clipped pixels still consume a cycle, and vga_x/vga_y output the truncated values.
- cnt increments each cycle. When cnt = SIZE*SIZE-1, next state is DONE and cnt wraps to 0.

DONE:
- done[owner]=1 for one cycle and vga_plot=0.
- rr_ptr = (owner+1) mod N_REQ. Next state IDLE.

Timing and request rules:
- Request sampled in IDLE at cycle t. Pixel 0 and the grant pulse appear in cycle t+1. Last pixel in cycle t+SIZE². done in cycle t+SIZE²+1. Next grant no earlier than t+SIZE²+3.
- Coordinates and colour are captured only at grant; input changes afterwards are ignored.
- Dropping req during PLOT does not abort the operation.
- Outside PLOT, vga_plot=0 and vga_x, vga_y, vga_colour hold their last values.
- A requester holding req continuously is re-arbitrated after DONE. The round-robin pointer guarantees the other requesters are served before it is served again.
- done and grant are never asserted in the same cycle.

Test Plan:
- req=0001, x=10, y=20, colour=3'b111 -> grant=0001 at t+1. Sixteen plots cover (10..13, 20..23) in row-major order, starting at (10,20) and ending at (13,23). done=0001 at t+17. busy low at t+18.
- req=0110 held simultaneously, rr_ptr=0 -> requester 1 is granted first, then requester 2. After that, rr_ptr=3.
- req=1111 held continuously -> grant order 0,1,2,3,0. Each done precedes the next grant by 2 cycles.
- x=158, y=118, SIZE=4 -> only 4 of 16 cycles plot, at (158..159, 118..119). done still arrives at t+17.
- reset asserted at pixel 7 of an operation -> vga_plot and busy drop in the same cycle, with no done. After release, a new request is granted to the lowest-index requester, rr_ptr=0.
- req_x changed from 10 to 50 at pixel 3 -> all 16 pixels still use base x=10.
